mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipeline. The MEM stage is the older instruction, so data accesses have priority. A starvation counter guarantees forward progress for fetch. The block sequences each memory transaction through a small FSM, returns read data with a one-cycle ack pulse and exports a pipeline stall.

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins ties; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_cancel,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        pipe_stall
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       cancel_pending;
    logic       if_elig;
    logic       d_elig;
    logic       grant_d;
    logic       grant_i;

    // A port whose ack is showing this cycle still holds its request; mask it.
    always_comb begin
        if_elig = if_req & ~if_ack & ~if_cancel;
        d_elig  = d_req & ~d_ack;
        grant_d = (state == IDLE) & d_elig &
                  (~if_elig | (starve_cnt < STARVE_LIM));
        grant_i = (state == IDLE) & if_elig & ~grant_d;
    end

    assign pipe_stall = (if_req & ~if_ack) | (d_req & ~d_ack);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            starve_cnt     <= '0;
            cancel_pending <= 1'b0;
            if_ack         <= 1'b0;
            d_ack          <= 1'b0;
            if_rdata       <= '0;
            d_rdata        <= '0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;

            if (!if_req)
                starve_cnt <= '0;
            else if (grant_i)
                starve_cnt <= '0;
            else if (grant_d && if_elig && starve_cnt < STARVE_LIM)
                starve_cnt <= starve_cnt + 4'd1;

            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        state     <= BUSY_D;
                    end else if (grant_i) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        state     <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (if_cancel)
                        cancel_pending <= 1'b1;
                    // A killed fetch still finishes on the bus but is never reported.
                    if (mem_ready) begin
                        mem_req        <= 1'b0;
                        state          <= IDLE;
                        cancel_pending <= 1'b0;
                        if (!cancel_pending && !if_cancel) begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                        d_ack   <= 1'b1;
                        if (!mem_we)
                            d_rdata <= mem_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, starvation,
// cancel, store and asynchronous reset mid-transaction.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_cancel;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        pipe_stall;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_cancel  (if_cancel),
        .if_rdata   (if_rdata),
        .if_ack     (if_ack),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ack      (d_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .pipe_stall (pipe_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        if_cancel = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        tick();
        tick();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_d_ack", 32'(d_ack), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_stall", 32'(pipe_stall), 32'd0);
        reset = 1'b1;
        tick();

        // single fetch, ready on 2nd busy cycle
        if_req  = 1'b1;
        if_addr = 32'h40;
        tick();
        check("f_req1", 32'(mem_req), 32'd1);
        check("f_addr", mem_addr, 32'h40);
        check("f_we", 32'(mem_we), 32'd0);
        check("f_stall", 32'(pipe_stall), 32'd1);
        tick();
        check("f_req2", 32'(mem_req), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h8C010004;
        tick();
        mem_ready = 1'b0;
        check("f_req_drop", 32'(mem_req), 32'd0);
        check("f_ack", 32'(if_ack), 32'd1);
        check("f_rdata", if_rdata, 32'h8C010004);
        check("f_stall_ack", 32'(pipe_stall), 32'd0);
        tick();
        if_req = 1'b0;
        check("f_no_regrant", 32'(mem_req), 32'd0);
        check("f_ack_pulse", 32'(if_ack), 32'd0);
        tick();

        // contention: data first, fetch in the d_ack cycle
        if_req  = 1'b1;
        if_addr = 32'h44;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h100;
        tick();
        check("c_dfirst", mem_addr, 32'h100);
        check("c_req", 32'(mem_req), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h11112222;
        tick();
        d_req     = 1'b0;
        mem_ready = 1'b0;
        check("c_dack", 32'(d_ack), 32'd1);
        check("c_drdata", d_rdata, 32'h11112222);
        check("c_ifack0", 32'(if_ack), 32'd0);
        tick();
        check("c_igrant", mem_addr, 32'h44);
        check("c_ireq", 32'(mem_req), 32'd1);
        check("c_dack_pulse", 32'(d_ack), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h33334444;
        tick();
        mem_ready = 1'b0;
        if_req    = 1'b0;
        check("c_ifack", 32'(if_ack), 32'd1);
        check("c_ifrdata", if_rdata, 32'h33334444);
        tick();

        // starvation: fetch cancelled in each d_ack cycle keeps it waiting
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 32'h300;
        if_req    = 1'b1;
        if_addr   = 32'h500;
        mem_ready = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("s_dreq", 32'(mem_req), 32'd1);
            check("s_daddr", mem_addr, 32'h300);
            tick();
            check("s_dack", 32'(d_ack), 32'd1);
            if_cancel = 1'b1;
            tick();
            if_cancel = 1'b0;
            check("s_idle", 32'(mem_req), 32'd0);
        end
        tick();
        check("s_if_forced", mem_addr, 32'h500);
        check("s_if_we", 32'(mem_we), 32'd0);
        tick();
        check("s_ifack", 32'(if_ack), 32'd1);
        check("s_ifrdata", if_rdata, 32'hA5A5A5A5);
        check("s_dack0", 32'(d_ack), 32'd0);
        d_req     = 1'b0;
        if_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
        check("s_done", 32'(mem_req), 32'd0);

        // cancel in 1st BUSY_I cycle, ready 3 cycles later
        if_req  = 1'b1;
        if_addr = 32'h80;
        tick();
        check("k_req", 32'(mem_req), 32'd1);
        check("k_addr", mem_addr, 32'h80);
        if_cancel = 1'b1;
        tick();
        if_cancel = 1'b0;
        if_req    = 1'b0;
        tick();
        check("k_busy", 32'(mem_req), 32'd1);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_ready = 1'b0;
        check("k_drop", 32'(mem_req), 32'd0);
        check("k_noack", 32'(if_ack), 32'd0);
        check("k_rdata", if_rdata, 32'hA5A5A5A5);
        tick();
        check("k_noack2", 32'(if_ack), 32'd0);

        // fetch after cancel completes normally
        if_req  = 1'b1;
        if_addr = 32'h84;
        tick();
        check("r_addr", mem_addr, 32'h84);
        mem_ready = 1'b1;
        mem_rdata = 32'h0C0FFEE0;
        tick();
        mem_ready = 1'b0;
        if_req    = 1'b0;
        check("r_ack", 32'(if_ack), 32'd1);
        check("r_rdata", if_rdata, 32'h0C0FFEE0);
        tick();

        // store
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h200;
        d_wdata = 32'hDEADBEEF;
        tick();
        check("w_we", 32'(mem_we), 32'd1);
        check("w_addr", mem_addr, 32'h200);
        check("w_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        check("w_we_hold", 32'(mem_we), 32'd1);
        check("w_wdata_hold", mem_wdata, 32'hDEADBEEF);
        mem_ready = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_ready = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        check("w_dack", 32'(d_ack), 32'd1);
        check("w_drdata", d_rdata, 32'hA5A5A5A5);
        tick();

        // asynchronous reset during BUSY_D
        d_req  = 1'b1;
        d_addr = 32'h240;
        tick();
        check("x_busy", 32'(mem_req), 32'd1);
        #2;
        reset     = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("x_mem_req", 32'(mem_req), 32'd0);
        check("x_mem_addr", mem_addr, 32'd0);
        check("x_d_rdata", d_rdata, 32'd0);
        check("x_if_rdata", if_rdata, 32'd0);
        check("x_d_ack", 32'(d_ack), 32'd0);
        d_req = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        tick();
        check("x_noack1", 32'(d_ack), 32'd0);
        tick();
        check("x_noack2", 32'(d_ack), 32'd0);
        check("x_idle", 32'(mem_req), 32'd0);
        mem_ready = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
